// File: rtl/div_restoring.sv
// Sequential unsigned restoring divider: one quotient bit per SHIFT/SUB/CHECK pass,
// START/DONE four-phase handshake, divide-by-zero reported immediately.
module div_restoring #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         START,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         DONE,
  output logic         BUSY,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_SUB, S_CHECK, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [N:0]    a;
  logic [N-1:0]  q;
  logic [N-1:0]  m;
  logic [CW-1:0] cnt;
  logic          dz;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = (divisor == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: state_nxt = S_SUB;
      S_SUB:   state_nxt = S_CHECK;
      S_CHECK: state_nxt = (cnt == CW'(1)) ? S_DONE : S_SHIFT;
      S_DONE:  if (!START) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    DONE = (state == S_DONE);
    BUSY = (state == S_SHIFT) || (state == S_SUB) || (state == S_CHECK);
  end

  // Datapath registers; the sign bit A[N] after SUB decides restore vs. keep.
  always_ff @(posedge clk) begin
    if (rst) begin
      a   <= '0;
      q   <= '0;
      m   <= '0;
      cnt <= '0;
      dz  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            if (divisor != '0) begin
              a   <= '0;
              q   <= dividend;
              m   <= divisor;
              cnt <= CW'(N);
              dz  <= 1'b0;
            end else begin
              a   <= {1'b0, dividend};
              q   <= '1;
              dz  <= 1'b1;
            end
          end
        end
        S_SHIFT: {a, q} <= {a[N-1:0], q, 1'b0};
        S_SUB:   a <= a - {1'b0, m};
        S_CHECK: begin
          if (a[N]) begin
            a    <= a + {1'b0, m};
            q[0] <= 1'b0;
          end else begin
            q[0] <= 1'b1;
          end
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign quotient    = q;
  assign remainder   = a[N-1:0];
  assign div_by_zero = dz;

endmodule

// File: tb/tb_div_restoring.sv
// Randomized and directed checks of div_restoring at N=8 and N=16 against an
// arithmetic reference (/ and %), including latency, handshake and reset abort.
module tb_div_restoring;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [15:0] dd, dv;

  logic [7:0]  q8, r8;
  logic        done8, busy8, dz8;
  logic [15:0] q16, r16;
  logic        done16, busy16, dz16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_restoring #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .START(start8),
    .dividend(dd[7:0]), .divisor(dv[7:0]),
    .quotient(q8), .remainder(r8),
    .DONE(done8), .BUSY(busy8), .div_by_zero(dz8)
  );

  div_restoring #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .START(start16),
    .dividend(dd), .divisor(dv),
    .quotient(q16), .remainder(r16),
    .DONE(done16), .BUSY(busy16), .div_by_zero(dz16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rq(input int w);
    return (w == 8) ? {8'h00, q8} : q16;
  endfunction
  function automatic logic [15:0] rr(input int w);
    return (w == 8) ? {8'h00, r8} : r16;
  endfunction
  function automatic logic rdone(input int w);
    return (w == 8) ? done8 : done16;
  endfunction
  function automatic logic rbusy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction
  function automatic logic rdz(input int w);
    return (w == 8) ? dz8 : dz16;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 8) start8 = v;
    else        start16 = v;
  endtask

  // One full transaction: accept, wait for DONE (bounded), check results,
  // hold START high one more edge, then release and check results are held.
  task automatic run_op(input int w, input logic [15:0] a_in, input logic [15:0] b_in,
                        input bit noisy);
    logic [15:0] mask, a, b, eq, er;
    int          lat, exp_lat;
    bit          busy_ok;
    mask    = (w == 8) ? 16'h00ff : 16'hffff;
    a       = a_in & mask;
    b       = b_in & mask;
    eq      = (b == 16'd0) ? mask : (a / b);
    er      = (b == 16'd0) ? a : (a % b);
    exp_lat = (b == 16'd0) ? 0 : 3 * w;

    dd = a;
    dv = b;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    check("busy_after_e0", 32'(rbusy(w)), 32'(b != 16'd0));

    lat     = 0;
    busy_ok = 1'b1;
    while (!rdone(w) && lat < 400) begin
      if (!rbusy(w)) busy_ok = 1'b0;
      if (noisy) begin
        set_start(w, 1'($urandom));
        dd = 16'($urandom);
        dv = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (rdone(w) && rbusy(w)) busy_ok = 1'b0;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_window", 32'(busy_ok), 32'd1);
    check("quotient", 32'(rq(w)), 32'(eq));
    check("remainder", 32'(rr(w)), 32'(er));
    check("div_by_zero", 32'(rdz(w)), 32'(b == 16'd0));
    if (b != 16'd0) begin
      check("invariant", 32'(rq(w)) * 32'(b) + 32'(rr(w)), 32'(a));
      check("rem_lt_div", 32'(rr(w) < b), 32'd1);
    end

    set_start(w, 1'b1);
    dd = 16'($urandom);
    dv = 16'($urandom);
    @(posedge clk); #1;
    check("done_held", 32'(rdone(w)), 32'd1);
    check("q_held_done", 32'(rq(w)), 32'(eq));

    set_start(w, 1'b0);
    @(posedge clk); #1;
    check("done_released", 32'(rdone(w)), 32'd0);
    check("busy_idle", 32'(rbusy(w)), 32'd0);
    check("q_held_idle", 32'(rq(w)), 32'(eq));
    check("r_held_idle", 32'(rr(w)), 32'(er));
    check("dz_held_idle", 32'(rdz(w)), 32'(b == 16'd0));
  endtask

  function automatic logic [15:0] rand_divisor();
    int sel;
    sel = int'($urandom_range(0, 15));
    if (sel == 0) return 16'd0;
    if (sel == 1) return 16'd1;
    if (sel == 2) return 16'hffff;
    return 16'($urandom);
  endfunction

  initial begin
    rst     = 1'b1;
    start8  = 1'b0;
    start16 = 1'b0;
    dd      = '0;
    dv      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q8", 32'(q8), 32'd0);
    check("rst_r8", 32'(r8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_dz8", 32'(dz8), 32'd0);
    check("rst_q16", 32'(q16), 32'd0);
    check("rst_done16", 32'(done16), 32'd0);
    rst = 1'b0;

    run_op(8, 16'd100, 16'd7, 1'b0);
    run_op(8, 16'd255, 16'd1, 1'b0);
    run_op(8, 16'd255, 16'd255, 1'b0);
    run_op(8, 16'd5, 16'd9, 1'b0);
    run_op(8, 16'd0, 16'd3, 1'b0);
    run_op(8, 16'd77, 16'd0, 1'b0);
    run_op(8, 16'd77, 16'd11, 1'b0);
    run_op(8, 16'd200, 16'd13, 1'b1);

    // Abort 200/13 with reset sampled at e10 while START is still high.
    dd = 16'd200;
    dv = 16'd13;
    start8 = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_q", 32'(q8), 32'd0);
    check("abort_r", 32'(r8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_dz", 32'(dz8), 32'd0);
    rst = 1'b0;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done8), 32'd0);
    run_op(8, 16'd9, 16'd4, 1'b0);

    run_op(16, 16'd65535, 16'd0, 1'b0);
    run_op(16, 16'd65535, 16'd1, 1'b0);
    run_op(16, 16'd1000, 16'd33, 1'b0);

    for (int i = 0; i < 1200; i++)
      run_op(8, 16'($urandom), rand_divisor(), 1'(i % 7 == 0));
    for (int i = 0; i < 800; i++)
      run_op(16, 16'($urandom), rand_divisor(), 1'(i % 7 == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
